ram8: RTL and testbench

RAM8 -- requirements
Module: ram8

---
 rtl/ram8.sv | 56 +++++
 tb/tb_ram8.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ram8.sv
// 8-word register file: combinational read (0 cycles), write lands on the rising edge.
// Always accepts a write; wr_count tracks how many distinct words have been written.
module ram8 #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in,
   input  logic             load,
   input  logic [2:0]       address,
   output logic [WIDTH-1:0] out,
   output logic [3:0]       wr_count
);

   if (DEPTH != 8) begin : g_depth_check
      $error("ram8: DEPTH must be 8");
   end

   logic [WIDTH-1:0] r_mem [8];
   logic [7:0]       r_written;
   logic [3:0]       r_wr_count;
   logic             r_arm;
   logic             w_wr;

   // Arms on the falling edge after reset release, so a release that lands on a rising edge cannot write.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_arm <= 1'b0;
      end else begin
         r_arm <= 1'b1;
      end
   end

   assign w_wr = load & r_arm;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            r_mem[i] <= '0;
         end
         r_written  <= '0;
         r_wr_count <= '0;
      end else if (w_wr) begin
         r_mem[address] <= in;
         if (!r_written[address]) begin
            r_written[address] <= 1'b1;
            r_wr_count         <= r_wr_count + 4'd1;
         end
      end
   end

   assign out      = r_mem[address];
   assign wr_count = r_wr_count;

endmodule

// File: tb/tb_ram8.sv
// Directed bench for ram8: vector table plus hand-written reset and hold sequences.
module tb_ram8;

   logic        clk;
   logic        rst_n;
   logic [15:0] in;
   logic        load;
   logic [2:0]  address;
   logic [15:0] out;
   logic [3:0]  wr_count;

   ram8 #(.WIDTH(16), .DEPTH(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in       (in),
      .load     (load),
      .address  (address),
      .out      (out),
      .wr_count (wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ld;
      logic [2:0]  a;
      logic [15:0] d;
      logic [15:0] eo;
      logic [3:0]  ec;
   } vec_t;

   vec_t        vecs[$];
   logic [15:0] m[8];
   int          n_checks;
   int          n_err;

   task automatic add(input logic ld, input int a, input logic [15:0] d,
                      input logic [15:0] eo, input int ec);
      vec_t v;
      v.ld = ld;
      v.a  = 3'(a);
      v.d  = d;
      v.eo = eo;
      v.ec = 4'(ec);
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      n_checks = 0;
      n_err    = 0;

      // Power-up sweep, then write every word, read back, read-during-write and rewrites.
      for (int a = 0; a < 8; a++) add(1'b0, a, 16'hA5A5, 16'h0000, 0);
      for (int a = 0; a < 8; a++) add(1'b1, a, 16'(16'h1111 * (a + 1)), 16'h0000, a);
      for (int a = 0; a < 8; a++) add(1'b0, a, 16'h0000, 16'(16'h1111 * (a + 1)), 8);
      add(1'b1, 3, 16'h00AA, 16'h4444, 8);
      add(1'b0, 3, 16'h0000, 16'h00AA, 8);
      add(1'b1, 3, 16'hBEEF, 16'h00AA, 8);
      add(1'b0, 3, 16'h0000, 16'hBEEF, 8);
      add(1'b1, 5, 16'h1234, 16'h6666, 8);
      add(1'b1, 5, 16'h5678, 16'h1234, 8);
      add(1'b0, 5, 16'h0000, 16'h5678, 8);

      rst_n   = 1'b0;
      load    = 1'b0;
      in      = 16'h0000;
      address = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset wr_count", 32'(wr_count), 32'd0);
      chk("reset out", 32'(out), 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         load    = vecs[i].ld;
         address = vecs[i].a;
         in      = vecs[i].d;
         @(negedge clk);
         chk($sformatf("vec%0d out", i), 32'(out), 32'(vecs[i].eo));
         chk($sformatf("vec%0d wr_count", i), 32'(wr_count), 32'(vecs[i].ec));
         @(posedge clk);
         #1;
      end

      for (int a = 0; a < 8; a++) m[a] = 16'(16'h1111 * (a + 1));
      m[3] = 16'hBEEF;
      m[5] = 16'h5678;

      // Load-low hold: in/address wander, including between edges.
      load = 1'b0;
      for (int c = 0; c < 10; c++) begin
         address = 3'($urandom_range(7, 0));
         in      = 16'($urandom);
         #1;
         chk($sformatf("hold%0d out", c), 32'(out), 32'(m[address]));
         @(negedge clk);
         address = 3'($urandom_range(7, 0));
         in      = 16'($urandom);
         #1;
         chk($sformatf("hold%0d mid out", c), 32'(out), 32'(m[address]));
         @(posedge clk);
         #1;
      end
      for (int a = 0; a < 8; a++) begin
         address = 3'(a);
         #1;
         chk($sformatf("hold sweep a%0d", a), 32'(out), 32'(m[a]));
      end
      chk("hold wr_count", 32'(wr_count), 32'd8);

      // Async reset mid-operation.
      load    = 1'b1;
      address = 3'd7;
      in      = 16'hFFFF;
      @(posedge clk);
      #1;
      load = 1'b0;
      @(negedge clk);
      chk("pre-reset a7", 32'(out), 32'hFFFF);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset out", 32'(out), 32'h0);
      chk("async reset wr_count", 32'(wr_count), 32'd0);

      // Writes during reset are ignored.
      load    = 1'b1;
      address = 3'd2;
      in      = 16'h5555;
      @(posedge clk);
      #1;
      chk("write in reset", 32'(out), 32'h0);

      // Release on a rising edge: that edge must not write; the next one does.
      @(posedge clk);
      rst_n = 1'b1;
      #1;
      chk("coincident release out", 32'(out), 32'h0);
      chk("coincident release wr_count", 32'(wr_count), 32'd0);
      @(posedge clk);
      #1;
      chk("first write after reset", 32'(out), 32'h5555);
      chk("first write wr_count", 32'(wr_count), 32'd1);
      load    = 1'b0;
      address = 3'd7;
      #1;
      chk("a7 cleared", 32'(out), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
